// File: rtl/apb_wrr_arbiter.sv
// apb_wrr_arbiter: weighted round-robin arbiter between an APB write path
// and an APB read path. Each side owns a 4-bit credit that is spent one per
// completed transfer; the priority bit moves to the other side when the
// credit runs out, or when the other side has nothing pending.
//
// Optional build macro: APB_ARB_WATCHDOG_EN
//   defined   - a 16-bit watchdog aborts a busy state that sees no done
//               within TimeoutCycles enabled cycles.
//   undefined - no watchdog, abort is held at 0.
//
// Handshake: req is a level meaning "a complete transfer is ready". A grant
// is held from the cycle after the deciding edge until the edge that samples
// done=1. Request changes are ignored while a grant is held.

module apb_wrr_arbiter #(
  parameter int WWeight       = 2,
  parameter int RWeight       = 2,
  parameter int TimeoutCycles = 256
) (
  input  logic       a_clk,
  input  logic       a_reset_n,
  input  logic       p_clk_en,
  input  logic       w_req,
  input  logic       r_req,
  input  logic       done,
  output logic       w_grant,
  output logic       r_grant,
  output logic       abort,
  output logic [1:0] state_dbg
);

  // Reject illegal parameter values at elaboration time.
  if (WWeight < 1 || WWeight > 15 || RWeight < 1 || RWeight > 15 ||
      TimeoutCycles < 2 || TimeoutCycles > 65535) begin : g_param_check
    $error("apb_wrr_arbiter: parameter out of legal range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WBUSY = 2'd1,
    RBUSY = 2'd2
  } state_t;

  localparam logic [3:0] WLoad = 4'(WWeight);
  localparam logic [3:0] RLoad = 4'(RWeight);

  state_t     state_q, state_d;
  logic       prio_w_q, prio_w_d;    // 1: write side wins a tie
  logic [3:0] w_cred_q, w_cred_d;
  logic [3:0] r_cred_q, r_cred_d;
  logic [3:0] w_dec, r_dec;          // credit after spending one, floored at 0
  logic       timeout;

  assign w_dec = (w_cred_q != 4'd0) ? (w_cred_q - 4'd1) : 4'd0;
  assign r_dec = (r_cred_q != 4'd0) ? (r_cred_q - 4'd1) : 4'd0;

`ifdef APB_ARB_WATCHDOG_EN
  localparam logic [15:0] WdLast = 16'(TimeoutCycles - 1);

  logic [15:0] wd_q, wd_d;
  logic        abort_q;

  // A done in the same cycle as the limit wins, so timeout requires !done.
  assign timeout = (state_q != IDLE) && p_clk_en && !done && (wd_q == WdLast);

  // Watchdog count: zero while idle so it starts clean on entry to busy.
  always_comb begin
    wd_d = wd_q;
    if (state_q == IDLE) begin
      wd_d = 16'd0;
    end else if (p_clk_en) begin
      wd_d = wd_q + 16'd1;
    end
  end

  // Watchdog and abort pulse registers.
  always_ff @(posedge a_clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      wd_q    <= 16'd0;
      abort_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      abort_q <= timeout;
    end
  end

  assign abort = abort_q;
`else
  assign timeout = 1'b0;
  assign abort   = 1'b0;
`endif

  // State, priority and credit registers.
  always_ff @(posedge a_clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state_q  <= IDLE;
      prio_w_q <= 1'b1;
      w_cred_q <= WLoad;
      r_cred_q <= RLoad;
    end else begin
      state_q  <= state_d;
      prio_w_q <= prio_w_d;
      w_cred_q <= w_cred_d;
      r_cred_q <= r_cred_d;
    end
  end

  // Next-state, priority and credit update.
  always_comb begin
    state_d  = state_q;
    prio_w_d = prio_w_q;
    w_cred_d = w_cred_q;
    r_cred_d = r_cred_q;
    case (state_q)
      IDLE: begin
        if (p_clk_en) begin
          if (w_req && (!r_req || prio_w_q)) begin
            state_d = WBUSY;
          end else if (r_req) begin
            state_d = RBUSY;
          end
        end
      end
      WBUSY: begin
        if (done) begin
          state_d  = IDLE;
          w_cred_d = w_dec;
          if (w_dec == 4'd0 || !r_req) begin
            prio_w_d = 1'b0;
            r_cred_d = RLoad;
          end
        end
      end
      RBUSY: begin
        if (done) begin
          state_d  = IDLE;
          r_cred_d = r_dec;
          if (r_dec == 4'd0 || !w_req) begin
            prio_w_d = 1'b1;
            w_cred_d = WLoad;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d  = IDLE;
      prio_w_d = !prio_w_q;
      w_cred_d = WLoad;
      r_cred_d = RLoad;
    end
  end

  // Outputs decode straight from the state register.
  always_comb begin
    w_grant   = (state_q == WBUSY);
    r_grant   = (state_q == RBUSY);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_apb_wrr_arbiter.sv
// Directed bench for apb_wrr_arbiter: default weights (instance a),
// 3:1 weights (instance b) and, when the watchdog macro is defined,
// a TimeoutCycles=4 instance (c). All instances share the stimulus.

module tb_apb_wrr_arbiter;

  // Clock and reset
  logic clk;
  logic rst_n;
  logic en, wr, rd, done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic       wg_a, rg_a, ab_a;
  logic [1:0] st_a;
  logic       wg_b, rg_b, ab_b;
  logic [1:0] st_b;

  int n_cmp  = 0;
  int n_fail = 0;

  apb_wrr_arbiter u_dut_a (
    .a_clk(clk), .a_reset_n(rst_n), .p_clk_en(en), .w_req(wr), .r_req(rd),
    .done(done), .w_grant(wg_a), .r_grant(rg_a), .abort(ab_a), .state_dbg(st_a)
  );

  apb_wrr_arbiter #(.WWeight(3), .RWeight(1)) u_dut_b (
    .a_clk(clk), .a_reset_n(rst_n), .p_clk_en(en), .w_req(wr), .r_req(rd),
    .done(done), .w_grant(wg_b), .r_grant(rg_b), .abort(ab_b), .state_dbg(st_b)
  );

`ifdef APB_ARB_WATCHDOG_EN
  logic       wg_c, rg_c, ab_c;
  logic [1:0] st_c;

  apb_wrr_arbiter #(.TimeoutCycles(4)) u_dut_c (
    .a_clk(clk), .a_reset_n(rst_n), .p_clk_en(en), .w_req(wr), .r_req(rd),
    .done(done), .w_grant(wg_c), .r_grant(rg_c), .abort(ab_c), .state_dbg(st_c)
  );
`endif

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    done  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  logic [7:0] exp_a;
  logic [7:0] exp_b;
  logic [1:0] side_a, side_b;

  initial begin
    // Reset state
    do_reset();
    check("reset_grants_a", {6'd0, wg_a, rg_a}, 8'h00);
    check("reset_abort_a", {7'd0, ab_a}, 8'h00);
    check("reset_state_a", {6'd0, st_a}, 8'h00);

    // Single write transfer, request dropped mid-transfer is ignored
    en = 1'b1;
    wr = 1'b1;
    tick();
    check("w_only_grant", {6'd0, wg_a, rg_a}, 8'h02);
    wr = 1'b0;
    tick();
    check("w_hold_1", {6'd0, wg_a, rg_a}, 8'h02);
    tick();
    check("w_hold_2", {6'd0, wg_a, rg_a}, 8'h02);
    pulse_done();
    check("w_drop_after_done", {6'd0, wg_a, rg_a}, 8'h00);
    tick();
    check("w_idle_no_req", {6'd0, wg_a, rg_a}, 8'h00);
    check("w_abort_quiet", {7'd0, ab_a}, 8'h00);

    // Weighted order; done pulses in IDLE must not consume credit
    do_reset();
    en = 1'b1;
    pulse_done();
    pulse_done();
    check("idle_done_no_grant", {4'd0, wg_a, rg_a, wg_b, rg_b}, 8'h00);
    wr = 1'b1;
    rd = 1'b1;
    exp_a = 8'b1100_1100;   // W,W,R,R,W,W,R,R
    exp_b = 8'b1110_1110;   // W,W,W,R,W,W,W,R
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 6; k++) begin
        tick();
        if (wg_a || rg_a) break;
      end
      side_a = exp_a[7-i] ? 2'b10 : 2'b01;
      side_b = exp_b[7-i] ? 2'b10 : 2'b01;
      check($sformatf("order_a_%0d", i), {6'd0, wg_a, rg_a}, {6'd0, side_a});
      check($sformatf("order_b_%0d", i), {6'd0, wg_b, rg_b}, {6'd0, side_b});
      pulse_done();
    end
    wr = 1'b0;
    rd = 1'b0;

    // Clock enable low blocks decisions
    do_reset();
    wr = 1'b1;
    rd = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("en_low_%0d", k), {6'd0, wg_a, rg_a}, 8'h00);
    end
    en = 1'b1;
    tick();
    check("en_return_grant", {6'd0, wg_a, rg_a}, 8'h02);

    // Reach RBUSY, then reset asynchronously in the middle of it
    pulse_done();
    tick();
    check("second_w", {6'd0, wg_a, rg_a}, 8'h02);
    pulse_done();
    tick();
    check("first_r", {6'd0, wg_a, rg_a}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", {6'd0, wg_a, rg_a}, 8'h00);
    #3;
    rst_n = 1'b1;
    tick();
    check("post_reset_w_first", {6'd0, wg_a, rg_a}, 8'h02);

`ifdef APB_ARB_WATCHDOG_EN
    // Watchdog: no done, abort four cycles after the grant
    do_reset();
    en = 1'b1;
    wr = 1'b1;
    rd = 1'b1;
    tick();
    check("wd_grant", {5'd0, ab_c, wg_c, rg_c}, 8'h02);
    for (int k = 1; k < 4; k++) begin
      tick();
      check($sformatf("wd_wait_%0d", k), {5'd0, ab_c, wg_c, rg_c}, 8'h02);
    end
    tick();
    check("wd_abort", {5'd0, ab_c, wg_c, rg_c}, 8'h04);
    tick();
    check("wd_opposite", {5'd0, ab_c, wg_c, rg_c}, 8'h01);
`endif

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_wrr_arbiter.md
APB_WRR_ARBITER -- requirements
Module: apb_wrr_arbiter

Interface
REQ-001 Parameter WWeight, default 2, maximum back-to-back write grants while reads are pending; legal range 1..15.
REQ-002 Parameter RWeight, default 2, maximum back-to-back read grants while writes are pending; legal range 1..15.
REQ-003 Parameter TimeoutCycles, default 256, watchdog limit in enabled cycles; legal range 2..65535; used only with the macro in REQ-027.
REQ-004 a_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 a_reset_n  input  1  asynchronous, active-low reset.
REQ-006 p_clk_en  input  1  APB clock enable; a grant decision is taken only in a cycle with p_clk_en=1.
REQ-007 w_req  input  1  write path has a complete transfer ready.
REQ-008 r_req  input  1  read path has a complete transfer ready.
REQ-009 done  input  1  single-cycle pulse from the APB controller; the granted transfer completed this cycle.
REQ-010 w_grant  output  1  registered; the APB bus is owned by the write path.
REQ-011 r_grant  output  1  registered; the APB bus is owned by the read path.
REQ-012 abort  output  1  registered single-cycle pulse; the watchdog fired (REQ-028); held 0 when the macro is absent.

Function
REQ-013 The FSM shall have exactly three states: IDLE, WBUSY, RBUSY; w_grant=1 iff WBUSY, r_grant=1 iff RBUSY, never both.
REQ-014 IDLE with p_clk_en=1: only w_req -> WBUSY; only r_req -> RBUSY; both -> the side indicated by the priority bit.
REQ-015 IDLE with p_clk_en=0, or with no request, shall remain IDLE.
REQ-016 Grant latency: the grant is asserted in the cycle after the deciding edge (1 cycle).
REQ-017 WBUSY/RBUSY shall hold the grant, ignoring request changes, until done=1 is sampled; next state is IDLE, so the grant drops one cycle after done.
REQ-018 done sampled in IDLE shall be ignored.
REQ-019 Credit counters w_cred and r_cred, each 4 bits, shall be decremented by 1 on every done of their own side.
REQ-020 On a done that brings the side's credit to 0, or on any done while the opposite request is 0, the priority bit shall point to the opposite side and that side's credit shall reload to its weight. In the second case the opposite side is idle, so the current side keeps winning through REQ-014.
REQ-021 A side's credit shall never decrement below 0 and shall never exceed its weight.
REQ-022 Worst-case wait for a continuously asserted request shall be max(WWeight, RWeight) transfers of the other side.
REQ-023 w_req and r_req both rising in the same IDLE cycle shall be resolved by the priority bit only, with no extra cycle of latency.

Reset
REQ-024 While a_reset_n=0, asynchronously: state=IDLE, w_grant=0, r_grant=0, abort=0, priority=write, w_cred=WWeight, r_cred=RWeight, watchdog=0.
REQ-025 Reset asserted mid-transfer shall drop the grant immediately, with no completion and no credit update.
REQ-026 After reset release the first decision shall occur at the first edge with p_clk_en=1 and a request present.

Configuration
REQ-027 Macro APB_ARB_WATCHDOG_EN defined: a 16-bit watchdog shall clear on entry to WBUSY or RBUSY and increment on each p_clk_en=1 cycle while busy.
REQ-028 With APB_ARB_WATCHDOG_EN defined, when the watchdog reaches TimeoutCycles without done, the block shall:
- pulse abort for one cycle;
- return to IDLE;
- flip the priority bit and reload both credits.
REQ-029 With APB_ARB_WATCHDOG_EN defined, done and timeout in the same cycle shall be treated as done, with no abort.
REQ-030 Macro APB_ARB_WATCHDOG_EN undefined: no watchdog logic, abort tied to 0, and a busy state waits for done indefinitely.

Verification
REQ-031 Only w_req=1 with p_clk_en=1 -> w_grant=1 in the next cycle; done after 3 cycles -> w_grant=0 in the following cycle; r_grant stays 0 throughout.
REQ-032 w_req=r_req=1 continuously with defaults -> grant order W,W,R,R,W,W over 6 transfers.
REQ-033 WWeight=3, RWeight=1, both requests held -> W,W,W,R,W,W,W,R; a read waits at most 3 transfers.
REQ-034 p_clk_en=0 for 5 cycles with both requests pending -> no grant; first grant arrives one cycle after p_clk_en returns to 1.
REQ-035 a_reset_n pulled low in the middle of RBUSY -> r_grant=0 asynchronously; after release with both requests -> write granted first.
REQ-036 APB_ARB_WATCHDOG_EN defined, TimeoutCycles=4, p_clk_en=1, done never asserted -> abort pulses 4 cycles after the grant, the grant drops, and the opposite side is granted next.
